// File: rtl/tetris_pkg.sv
// Shared definitions for the playfield and the falling-block controller:
// field geometry, the playfield FSM state type and the score ceiling.
package tetris_pkg;

   localparam int unsigned COLS      = 10;   // columns in the field
   localparam int unsigned ROWS      = 20;   // rows in the field
   localparam int unsigned CELL      = 16;   // cell edge in pixels
   localparam int unsigned X0        = 250;  // left pixel edge of the field
   localparam int unsigned Y0        = 100;  // top pixel edge of the field
   localparam int unsigned MAX_SPAN  = 4;    // largest block extent in cells
   localparam int unsigned SCORE_MAX = 9999;

   localparam logic [1:0] GAME_PLAY = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOCK,
      ST_SCAN,
      ST_SHIFT
   } grid_state_t;

endpackage

// File: rtl/grid_probe.sv
// Combinational occupancy probes around the falling block.
// Ports:
//   i_grid      occupancy, row-major, bit c of row r = cell (r, c)
//   i_cx, i_ry  block column / row index
//   i_w, i_h    block width / height in cells
//   i_touching  block has reached the floor
//   o_stop_left / o_stop_right  sideways move blocked
//   o_landed    block rests on the floor or on an occupied cell
module grid_probe
   import tetris_pkg::*;
#(
   parameter int unsigned COLS = tetris_pkg::COLS,
   parameter int unsigned ROWS = tetris_pkg::ROWS
) (
   input  logic [ROWS-1:0][COLS-1:0] i_grid,
   input  logic [9:0]                i_cx,
   input  logic [9:0]                i_ry,
   input  logic [9:0]                i_w,
   input  logic [9:0]                i_h,
   input  logic                      i_touching,
   output logic                      o_stop_left,
   output logic                      o_stop_right,
   output logic                      o_landed
);

   localparam int unsigned RW = $clog2(ROWS);
   localparam int unsigned CW = $clog2(COLS);

   always_comb begin
      int unsigned cx, ry, w, h, rr, cl, cr, below, cc;
      cx    = 32'(i_cx);
      ry    = 32'(i_ry);
      w     = 32'(i_w);
      h     = 32'(i_h);
      cl    = cx - 1;
      cr    = cx + w;
      below = ry + h;
      rr    = 0;
      cc    = 0;
      o_stop_left  = (cx == 0);
      o_stop_right = (cr >= COLS);
      o_landed     = i_touching;
      for (int unsigned i = 0; i < MAX_SPAN; i++) begin
         rr = ry + i;
         // Cells outside the field never block.
         if (i < h && rr < ROWS) begin
            if (cx > 0 && cl < COLS && i_grid[RW'(rr)][CW'(cl)])
               o_stop_left = 1'b1;
            if (cr < COLS && i_grid[RW'(rr)][CW'(cr)])
               o_stop_right = 1'b1;
         end
         cc = cx + i;
         if (i < w && below < ROWS && cc < COLS && i_grid[RW'(below)][CW'(cc)])
            o_landed = 1'b1;
      end
   end

endmodule

// File: rtl/playfield_grid.sv
// Playfield occupancy grid: locks landed blocks, clears full lines,
// counts cleared lines and flags game over.
// Ports:
//   frame_clk, Reset (async, active-high), game_reset (sync clear)
//   state       game state, grid active only in GAME_PLAY
//   touching    block reached the floor
//   shape_*     block pixel position and size
//   rd_row / rd_bits  combinational row read for drawing
//   stop_x_left / stop_x_right  sideways move blocked
//   shape_reset one-cycle pulse when the block is locked
//   Score, game_over, busy
module playfield_grid
   import tetris_pkg::*;
#(
   parameter int unsigned COLS = tetris_pkg::COLS,
   parameter int unsigned ROWS = tetris_pkg::ROWS,
   parameter int unsigned CELL = tetris_pkg::CELL,
   parameter int unsigned X0   = tetris_pkg::X0,
   parameter int unsigned Y0   = tetris_pkg::Y0
) (
   input  logic            frame_clk,
   input  logic            Reset,
   input  logic            game_reset,
   input  logic [1:0]      state,
   input  logic            touching,
   input  logic [9:0]      shape_x,
   input  logic [9:0]      shape_y,
   input  logic [9:0]      shape_size_x,
   input  logic [9:0]      shape_size_y,
   input  logic [4:0]      rd_row,
   output logic [COLS-1:0] rd_bits,
   output logic            stop_x_left,
   output logic            stop_x_right,
   output logic            shape_reset,
   output logic [13:0]     Score,
   output logic            game_over,
   output logic            busy
);

   localparam int unsigned RW = $clog2(ROWS);
   localparam int unsigned CW = $clog2(COLS);
   localparam int unsigned SH = $clog2(CELL);

   logic [ROWS-1:0][COLS-1:0] r_grid, w_grid_nxt;
   grid_state_t               r_fsm, w_fsm_nxt;
   logic [RW-1:0]             r_k, w_k_nxt;
   logic [13:0]               r_score, w_score_nxt;
   logic                      r_over, w_over_nxt;
   logic [9:0]                w_cx, w_ry, w_w, w_h;
   logic                      w_landed;

   assign w_cx = (shape_x - 10'(X0)) >> SH;
   assign w_ry = (shape_y - 10'(Y0)) >> SH;
   assign w_w  = shape_size_x >> SH;
   assign w_h  = shape_size_y >> SH;

   grid_probe #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_probe (
      .i_grid       (r_grid),
      .i_cx         (w_cx),
      .i_ry         (w_ry),
      .i_w          (w_w),
      .i_h          (w_h),
      .i_touching   (touching),
      .o_stop_left  (stop_x_left),
      .o_stop_right (stop_x_right),
      .o_landed     (w_landed)
   );

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_grid  <= '0;
         r_fsm   <= ST_IDLE;
         r_k     <= '0;
         r_score <= '0;
         r_over  <= 1'b0;
      end else begin
         r_grid  <= w_grid_nxt;
         r_fsm   <= w_fsm_nxt;
         r_k     <= w_k_nxt;
         r_score <= w_score_nxt;
         r_over  <= w_over_nxt;
      end
   end

   always_comb begin
      int unsigned h, lr, rr, cc;
      w_grid_nxt  = r_grid;
      w_fsm_nxt   = r_fsm;
      w_k_nxt     = r_k;
      w_score_nxt = r_score;
      w_over_nxt  = r_over;
      shape_reset = 1'b0;
      h  = 32'(w_h);
      lr = (h >= ROWS) ? 0 : ((32'(w_ry) > ROWS - h) ? ROWS - h : 32'(w_ry));
      rr = 0;
      cc = 0;
      if (game_reset) begin
         w_grid_nxt  = '0;
         w_fsm_nxt   = ST_IDLE;
         w_k_nxt     = '0;
         w_score_nxt = '0;
         w_over_nxt  = 1'b0;
      end else if (state != GAME_PLAY) begin
         // Leaving play aborts any lock or clear in progress without touching the grid.
         w_fsm_nxt = ST_IDLE;
      end else begin
         unique case (r_fsm)
            ST_IDLE: begin
               if (w_landed && !r_over)
                  w_fsm_nxt = ST_LOCK;
            end
            ST_LOCK: begin
               shape_reset = 1'b1;
               for (int unsigned i = 0; i < MAX_SPAN; i++) begin
                  for (int unsigned j = 0; j < MAX_SPAN; j++) begin
                     rr = lr + i;
                     cc = 32'(w_cx) + j;
                     if (i < h && j < 32'(w_w) && rr < ROWS && cc < COLS)
                        w_grid_nxt[RW'(rr)][CW'(cc)] = 1'b1;
                  end
               end
               if (lr == 0)
                  w_over_nxt = 1'b1;
               w_k_nxt   = RW'(ROWS - 1);
               w_fsm_nxt = ST_SCAN;
            end
            ST_SCAN: begin
               if (&r_grid[r_k])
                  w_fsm_nxt = ST_SHIFT;
               else if (r_k == '0)
                  w_fsm_nxt = ST_IDLE;
               else
                  w_k_nxt = r_k - RW'(1);
            end
            ST_SHIFT: begin
               // k stays put so the row that dropped into it is checked again.
               for (int unsigned r = 1; r < ROWS; r++) begin
                  if (r <= 32'(r_k))
                     w_grid_nxt[RW'(r)] = r_grid[RW'(r - 1)];
               end
               w_grid_nxt[0] = '0;
               if (r_score != 14'(SCORE_MAX))
                  w_score_nxt = r_score + 14'd1;
               w_fsm_nxt = ST_SCAN;
            end
            default: w_fsm_nxt = ST_IDLE;
         endcase
      end
   end

   assign rd_bits   = (32'(rd_row) < ROWS) ? r_grid[RW'(rd_row)] : '0;
   assign Score     = r_score;
   assign game_over = r_over;
   assign busy      = (r_fsm != ST_IDLE);

endmodule

// File: tb/tb_playfield_grid.sv
module tb_playfield_grid;

   localparam int NC = 10;
   localparam int NR = 20;

   logic        frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   logic        Reset, game_reset, touching;
   logic [1:0]  state;
   logic [9:0]  shape_x, shape_y, shape_size_x, shape_size_y;
   logic [4:0]  rd_row;
   logic [9:0]  rd_bits;
   logic        stop_x_left, stop_x_right, shape_reset, game_over, busy;
   logic [13:0] Score;

   playfield_grid #(.COLS(10), .ROWS(20), .CELL(16), .X0(250), .Y0(100)) dut (
      .frame_clk(frame_clk), .Reset(Reset), .game_reset(game_reset), .state(state),
      .touching(touching), .shape_x(shape_x), .shape_y(shape_y),
      .shape_size_x(shape_size_x), .shape_size_y(shape_size_y), .rd_row(rd_row),
      .rd_bits(rd_bits), .stop_x_left(stop_x_left), .stop_x_right(stop_x_right),
      .shape_reset(shape_reset), .Score(Score), .game_over(game_over), .busy(busy));

   // Narrow, short field used to reach the score ceiling quickly.
   logic        b_touching;
   logic [4:0]  b_rd_row;
   logic [3:0]  b_rd_bits;
   logic        b_stop_l, b_stop_r, b_shape_reset, b_game_over, b_busy;
   logic [13:0] b_Score;

   playfield_grid #(.COLS(4), .ROWS(5), .CELL(16), .X0(250), .Y0(100)) dut2 (
      .frame_clk(frame_clk), .Reset(Reset), .game_reset(game_reset), .state(state),
      .touching(b_touching), .shape_x(10'd250), .shape_y(10'd116),
      .shape_size_x(10'd64), .shape_size_y(10'd64), .rd_row(b_rd_row),
      .rd_bits(b_rd_bits), .stop_x_left(b_stop_l), .stop_x_right(b_stop_r),
      .shape_reset(b_shape_reset), .Score(b_Score), .game_over(b_game_over), .busy(b_busy));

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_grid[NR][NC];
   int m_score;
   bit m_go;
   bit m_valid = 1'b0;

   task automatic m_clear();
      foreach (m_grid[r, c]) m_grid[r][c] = 1'b0;
      m_score = 0;
      m_go    = 1'b0;
   endtask

   function automatic int m_row(input int r);
      int v = 0;
      for (int c = 0; c < NC; c++) if (m_grid[r][c]) v |= (1 << c);
      return v;
   endfunction

   function automatic void m_geom(output int cx, output int ry, output int w, output int h);
      cx = ((int'(shape_x) - 250 + 1024) % 1024) / 16;
      ry = ((int'(shape_y) - 100 + 1024) % 1024) / 16;
      w  = int'(shape_size_x) / 16;
      h  = int'(shape_size_y) / 16;
   endfunction

   function automatic int m_stop_left();
      int cx, ry, w, h;
      m_geom(cx, ry, w, h);
      if (cx == 0) return 1;
      for (int r = ry; r < ry + h; r++)
         if (r < NR && cx - 1 < NC && m_grid[r][cx-1]) return 1;
      return 0;
   endfunction

   function automatic int m_stop_right();
      int cx, ry, w, h;
      m_geom(cx, ry, w, h);
      if (cx + w >= NC) return 1;
      for (int r = ry; r < ry + h; r++)
         if (r < NR && m_grid[r][cx+w]) return 1;
      return 0;
   endfunction

   // Place the block, then drop out every full line at once.
   task automatic m_lock(input int col, input int row, input int wc, input int hc, output int ncl);
      bit tmp[NR][NC];
      bit full;
      int lr, dst;
      lr = (row > NR - hc) ? NR - hc : row;
      for (int i = 0; i < hc; i++)
         for (int j = 0; j < wc; j++)
            if (col + j < NC) m_grid[lr+i][col+j] = 1'b1;
      if (lr == 0) m_go = 1'b1;
      foreach (tmp[r, c]) tmp[r][c] = 1'b0;
      ncl = 0;
      dst = NR - 1;
      for (int r = NR - 1; r >= 0; r--) begin
         full = 1'b1;
         for (int c = 0; c < NC; c++) if (!m_grid[r][c]) full = 1'b0;
         if (full) ncl++;
         else begin
            for (int c = 0; c < NC; c++) tmp[dst][c] = m_grid[r][c];
            dst--;
         end
      end
      foreach (tmp[r, c]) m_grid[r][c] = tmp[r][c];
      m_score = (m_score + ncl > 9999) ? 9999 : m_score + ncl;
   endtask

   // ---------------- continuous compare ----------------
   always @(negedge frame_clk) begin
      if (m_valid && !Reset && !busy) begin
         check("stop_left", stop_x_left, m_stop_left());
         check("stop_right", stop_x_right, m_stop_right());
         check("score", Score, m_score);
         check("game_over", game_over, m_go);
         check("shape_reset_idle", shape_reset, 0);
         if (rd_row < NR) check("rd_bits", rd_bits, m_row(rd_row));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic park();
      shape_x = 10'd442;  // column 12, outside the field
      shape_y = 10'd100;
      shape_size_x = 10'd16;
      shape_size_y = 10'd16;
   endtask

   task automatic set_shape(input int col, input int row, input int wc, input int hc, input bit tch);
      @(posedge frame_clk); #2;
      shape_x = 10'(250 + 16 * col);
      shape_y = 10'(100 + 16 * row);
      shape_size_x = 10'(16 * wc);
      shape_size_y = 10'(16 * hc);
      touching = tch;
   endtask

   task automatic wait_pulse(input string nm);
      int n = 0;
      while (!shape_reset && n < 10) begin
         @(posedge frame_clk); #2;
         n++;
      end
      check(nm, shape_reset, 1);
   endtask

   task automatic drop(input int col, input int row, input int wc, input int hc, input bit tch);
      int cnt, ncl;
      m_valid = 1'b0;
      set_shape(col, row, wc, hc, tch);
      wait_pulse("lock_pulse");
      touching = 1'b0;
      cnt = 1;
      @(posedge frame_clk); #2;
      park();
      while (busy && cnt < 60) begin
         cnt++;
         @(posedge frame_clk); #2;
      end
      m_lock(col, row, wc, hc, ncl);
      check("busy_cycles", cnt, 1 + NR + 2 * ncl);
      m_valid = 1'b1;
   endtask

   task automatic expect_no_lock(input string nm);
      touching = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge frame_clk); #2;
         check({nm, "_pulse"}, shape_reset, 0);
         check({nm, "_busy"}, busy, 0);
      end
      touching = 1'b0;
      park();
   endtask

   task automatic do_game_reset();
      @(posedge frame_clk); #2;
      m_valid = 1'b0;
      game_reset = 1'b1;
      @(posedge frame_clk); #2;
      game_reset = 1'b0;
      m_clear();
      m_valid = 1'b1;
   endtask

   task automatic rd_chk(input string nm, input int row, input int exp);
      @(posedge frame_clk); #2;
      rd_row = 5'(row);
      #1;
      check(nm, rd_bits, exp);
   endtask

   task automatic check_all_rows(input string nm);
      for (int r = 0; r < NR; r++) rd_chk(nm, r, 0);
      rd_row = 5'd19;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int berr;
      Reset = 1'b1; game_reset = 1'b0; touching = 1'b0; state = 2'd2;
      rd_row = 5'd19; b_touching = 1'b0; b_rd_row = 5'd4;
      park();
      m_clear();
      #1;
      check("rst_score", Score, 0);
      check("rst_game_over", game_over, 0);
      check("rst_shape_reset", shape_reset, 0);
      check("rst_busy", busy, 0);
      check("rst_row19", rd_bits, 0);
      @(posedge frame_clk); #2;
      Reset = 1'b0;
      m_valid = 1'b1;

      // First block on the floor of an empty field.
      drop(0, 19, 1, 1, 1'b1);
      rd_chk("first_cell", 19, 1);
      check("first_score", Score, 0);

      // Fill row 19 except column 9, put a marker at (18,0), then complete the line.
      for (int c = 1; c < 9; c++) drop(c, 19, 1, 1, 1'b1);
      drop(0, 18, 1, 1, 1'b1);
      rd_chk("row19_before", 19, 10'h1FF);
      drop(9, 19, 1, 1, 1'b1);
      rd_chk("row19_after_shift", 19, 1);
      rd_chk("row18_after_shift", 18, 0);
      check("one_line_score", Score, 1);

      // Four lines cleared by one vertical bar.
      do_game_reset();
      check("gr_score", Score, 0);
      drop(0, 16, 4, 4, 1'b1);
      drop(5, 16, 4, 4, 1'b1);
      drop(9, 16, 1, 4, 1'b1);
      rd_chk("row16_gap", 16, 10'h3EF);
      drop(4, 16, 1, 4, 1'b1);
      check("four_line_score", Score, 4);
      check_all_rows("four_line_empty");

      // Asynchronous reset while a line is being shifted.
      for (int c = 0; c < 9; c++) drop(c, 19, 1, 1, 1'b1);
      m_valid = 1'b0;
      set_shape(9, 19, 1, 1, 1'b1);
      wait_pulse("shift_lock_pulse");
      touching = 1'b0;
      @(posedge frame_clk); #2;
      park();
      @(posedge frame_clk); #2;
      check("busy_in_shift", busy, 1);
      Reset = 1'b1;
      #1;
      check("areset_busy", busy, 0);
      check("areset_shape_reset", shape_reset, 0);
      check("areset_score", Score, 0);
      check("areset_game_over", game_over, 0);
      check("areset_row19", rd_bits, 0);
      m_clear();
      @(posedge frame_clk); #2;
      Reset = 1'b0;
      m_valid = 1'b1;
      check_all_rows("areset_empty");

      // Side probes around cell (5,3).
      drop(3, 5, 1, 1, 1'b1);
      set_shape(4, 5, 1, 1, 1'b0);
      #1;
      check("probe_left_blocked", stop_x_left, 1);
      check("probe_right_free", stop_x_right, 0);
      set_shape(9, 5, 1, 1, 1'b0);
      #1;
      check("probe_right_edge", stop_x_right, 1);
      check("probe_left_free", stop_x_left, 0);
      set_shape(0, 10, 1, 1, 1'b0);
      #1;
      check("probe_left_edge", stop_x_left, 1);
      // Landing on an occupied cell without touching.
      drop(3, 4, 1, 1, 1'b0);
      rd_chk("stacked_row4", 4, 8);
      // Lock row clamped to the floor.
      drop(7, 19, 1, 2, 1'b1);
      rd_chk("clamp_row19", 19, 128);
      rd_chk("clamp_row18", 18, 128);
      rd_row = 5'd19;

      // Outside play nothing locks.
      @(posedge frame_clk); #2;
      state = 2'd1;
      shape_x = 10'd250; shape_y = 10'd404;
      expect_no_lock("not_play");
      @(posedge frame_clk); #2;
      state = 2'd2;

      // Game over on a lock in row 0.
      drop(0, 0, 1, 1, 1'b1);
      check("game_over_set", game_over, 1);
      set_shape(5, 10, 1, 1, 1'b1);
      expect_no_lock("after_over");
      do_game_reset();
      check("gr_game_over", game_over, 0);
      check("gr_score2", Score, 0);
      check_all_rows("gr_empty");

      // Score ceiling on the small field: four lines per lock.
      berr = 0;
      for (int it = 0; it < 2500; it++) begin
         int n;
         @(posedge frame_clk); #2;
         b_touching = 1'b1;
         n = 0;
         while (!b_shape_reset && n < 10) begin
            @(posedge frame_clk); #2;
            n++;
         end
         if (!b_shape_reset) berr++;
         b_touching = 1'b0;
         n = 0;
         while (b_busy && n < 40) begin
            @(posedge frame_clk); #2;
            n++;
         end
         if (b_busy) berr++;
         if (it == 2498) check("sat_score_9996", b_Score, 9996);
         if (berr > 0) break;
      end
      check("sat_handshake", berr, 0);
      check("sat_score_9999", b_Score, 9999);
      #1;
      check("sat_row_empty", b_rd_bits, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
